// File: rtl/parity_rx_if.sv
// Bus bundle for the parity_rx serial receiver: serial input side plus
// word-level result side.
interface parity_rx_if #(
    parameter int wordsize = 8
);
    logic                bit_en;
    logic                rx;
    logic [wordsize-1:0] data;
    logic                valid;
    logic                parity_err;
    logic                frame_err;
    logic                busy;
    logic [7:0]          err_count;

    modport master (
        output bit_en, rx,
        input  data, valid, parity_err, frame_err, busy, err_count
    );

    modport slave (
        input  bit_en, rx,
        output data, valid, parity_err, frame_err, busy, err_count
    );
endinterface

// File: rtl/parity_rx.sv
// Even-parity serial frame receiver: start, wordsize data bits LSB first,
// parity, stop. Optional saturating error counter under PARITY_RX_ERRCNT_EN.
module parity_rx #(
    parameter int wordsize = 8
) (
    input logic        clk,
    input logic        rst_n,
    parity_rx_if.slave bus
);
    localparam int cnt_w = $clog2(wordsize + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]          state;
    logic [wordsize-1:0] shreg;
    logic [wordsize-1:0] shreg_next;
    logic [cnt_w-1:0]    cnt;
    logic                rx_par;
    logic [wordsize-1:0] data_q;
    logic                valid_q;
    logic                perr_q;
    logic                ferr_q;

    // New bit enters at the MSB so the first data bit ends up in bit 0.
    // NOTE: always_comb gives every target a default first, so no latch is inferred.
    always_comb begin
        shreg_next               = shreg >> 1;
        shreg_next[wordsize-1]   = bus.rx;
    end

    // NOTE: sequential state uses non-blocking assignments only; every register
    // here, including the shift register, has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            rx_par  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.bit_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.rx) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= shreg_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == cnt_w'(wordsize - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        rx_par <= bus.rx;
                        state  <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit still delivers the word; resync is just IDLE.
                        data_q  <= shreg;
                        perr_q  <= (rx_par != ^shreg);
                        ferr_q  <= !bus.rx;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_RX_ERRCNT_EN
    logic [7:0] err_q;

    // One increment per erroneous frame, even when both flags are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (valid_q && (perr_q || ferr_q) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_parity_rx.sv
// Self-checking bench for parity_rx (wordsize 8): vector table, multi-cycle
// corner sequences and randomized frames against a behavioural model.
module tb_parity_rx;
    logic clk;
    logic rst_n;

    parity_rx_if #(.wordsize(8)) bus ();

    parity_rx #(.wordsize(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rx_rec_t;

    typedef struct {
        logic [7:0] word;
        bit         par;
        bit         stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    rx_rec_t rxq[$];
    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    int      dbl      = 0;
    int      errs     = 0;
    logic    prev_valid = 1'b0;

    // Monitor: record every valid pulse and any pulse wider than one cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.valid) begin
            if (prev_valid) dbl++;
            rxq.push_back('{bus.data, bus.parity_err, bus.frame_err, cyc});
        end
        prev_valid = bus.valid;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_perr(logic [7:0] word, bit par);
        return ((($countones(word) + int'(par)) % 2) != 0);
    endfunction

    function automatic int exp_cnt(int n);
`ifdef PARITY_RX_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    // One strobe, occupying exactly `period` clocks starting at a negedge.
    task automatic strobe_bit(bit b, int period);
        bus.rx     = b;
        bus.bit_en = 1'b1;
        @(negedge clk);
        if (period > 1) begin
            bus.bit_en = 1'b0;
            repeat (period - 1) @(negedge clk);
        end
    endtask

    task automatic idle(int n);
        bus.rx     = 1'b1;
        bus.bit_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] word, bit par, bit stop, int period);
        strobe_bit(1'b0, period);
        for (int i = 0; i < 8; i++) strobe_bit(word[i], period);
        strobe_bit(par, period);
        strobe_bit(stop, period);
    endtask

    task automatic expect_frame(string name, logic [7:0] word, logic ep, logic ef);
        rx_rec_t r;
        int      n = 0;
        while (rxq.size() == 0 && n < 64) begin
            bus.bit_en = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, rxq.size(), 1);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            check({name, "_data"}, r.data, word);
            check({name, "_perr"}, r.perr, ep);
            check({name, "_ferr"}, r.ferr, ef);
        end
        rxq.delete();
        if (ep || ef) errs++;
    endtask

    initial begin
        vec_t    vecs[6];
        rx_rec_t r0, r1;
        logic [7:0] w;
        bit      p, s;
        int      per, gap;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n      = 1'b0;
        bus.rx     = 1'b1;
        bus.bit_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  bus.data, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_perr",  bus.parity_err, 0);
        check("rst_ferr",  bus.frame_err, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_errcnt", bus.err_count, 0);
        rst_n = 1'b1;
        idle(3);

        // Table vectors, strobe every 4 clocks.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].word, vecs[i].par, vecs[i].stop, 4);
            expect_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_perr, vecs[i].exp_ferr);
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), bus.busy, 0);
            check($sformatf("vec%0d_errcnt", i), bus.err_count, exp_cnt(errs));
        end

        // Busy rises once the start bit is taken.
        strobe_bit(1'b0, 4);
        check("busy_in_frame", bus.busy, 1);
        for (int i = 0; i < 8; i++) strobe_bit(1'b1, 4);
        strobe_bit(1'b0, 4);
        strobe_bit(1'b1, 4);
        expect_frame("busy_frame", 8'hFF, 1'b0, 1'b0);

        // bit_en held high, back-to-back frames without an idle bit.
        send_frame(8'h00, 1'b0, 1'b1, 1);
        send_frame(8'hFF, 1'b0, 1'b1, 1);
        idle(3);
        check("b2b_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            r0 = rxq.pop_front();
            r1 = rxq.pop_front();
            check("b2b_data0", r0.data, 8'h00);
            check("b2b_data1", r1.data, 8'hFF);
            check("b2b_spacing", r1.cyc - r0.cyc, 11);
            check("b2b_flags", {r0.perr, r0.ferr, r1.perr, r1.ferr}, 0);
        end
        rxq.delete();

        // Reset mid-frame after four data bits.
        strobe_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) strobe_bit(i[0], 4);
        rst_n = 1'b0;
        #1;
        check("midrst_data",  bus.data, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_busy",  bus.busy, 0);
        check("midrst_flags", {bus.parity_err, bus.frame_err}, 0);
        check("midrst_errcnt", bus.err_count, 0);
        errs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("midrst_no_valid", rxq.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        expect_frame("post_rst", 8'h5A, 1'b0, 1'b0);

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            w   = 8'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 3) != 0);
            per = $urandom_range(1, 5);
            gap = $urandom_range(0, 3);
            send_frame(w, p, s, per);
            expect_frame($sformatf("rnd%0d", i), w, model_perr(w, p), !s);
            if (gap > 0) idle(gap);
        end
        idle(3);
        check("rnd_errcnt", bus.err_count, exp_cnt(errs));

        // 300 bad-parity frames: counter saturates (or stays 0 without it).
        for (int i = 0; i < 300; i++) begin
            w = 8'($urandom);
            p = ~(^w);
            send_frame(w, p, 1'b1, 1);
            expect_frame("sat", w, 1'b1, 1'b0);
        end
        idle(3);
        check("sat_errcnt", bus.err_count, exp_cnt(errs));
        check("valid_one_cycle", dbl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parity_rx.md
# parity_rx

Serial receiver for parity-protected words: the receiving end of the even-parity scheme our `parity` generator produces (`parity = ^word`). Samples a single-wire serial frame (start bit, `wordsize` data bits LSB first, even-parity bit, stop bit) on an externally supplied bit strobe. Delivers the word with a one-cycle valid pulse plus parity-error and framing-error flags. Sits between a bit-rate strobe generator and any word-level consumer.

## Interface
- `wordsize`, 8, data bits per frame (≥1)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `bit_en`  input  1  bit-period strobe; `rx` sampled only on cycles with `bit_en`=1
- `rx`  input  1  serial line, idle high
- `data`  output  `wordsize`  last received word
- `valid`  output  1  one-cycle pulse: `data`/flags updated
- `parity_err`  output  1  parity mismatch of last frame
- `frame_err`  output  1  stop bit sampled low in last frame
- `busy`  output  1  FSM not in IDLE
- `err_count`  output  8  saturating error counter (see Configuration)

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on `bit_en`=1 cycles; with `bit_en`=0 state, shift register and bit counter hold.
- IDLE: `rx`=0 sampled → DATA, bit counter cleared. `rx`=1 → stay.
- DATA: shift `rx` in LSB first (first data bit lands in bit 0); after `wordsize` samples → PARITY. Counter width `$clog2(wordsize+1)`.
- PARITY: capture `rx` as received parity bit → STOP.
- STOP: sample `rx`; → IDLE unconditionally. On this edge: `data` ← shift register, `parity_err` ← (received parity != ^shift register), `frame_err` ← (`rx`==0), `valid` ← 1.
- Frame with `frame_err` still delivers data; no resync search beyond returning to IDLE (a low `rx` on the next strobe starts a new frame).
- `data`, `parity_err`, `frame_err` hold until the next frame completes.
- `busy` = (state != IDLE), combinational from state register.

## Timing
- Reset (async, `rst_n`=0): state IDLE; `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `err_count`=0, shift register and counter 0. Reset mid-frame abandons the frame; no `valid` is produced for it.
- Frame length `wordsize`+3 strobes. `valid` rises on the clock edge that samples the stop bit (visible the cycle after that strobe) and is high exactly one cycle.
- Back-to-back: a start bit on the strobe immediately after the stop strobe is accepted (no idle bit required).
- `bit_en` held high continuously is legal: one bit per clock.
- Outputs registered; no combinational path from `rx`/`bit_en` to any output.

## Configuration
- `PARITY_RX_ERRCNT_EN` defined: `err_count` increments by 1 on every `valid` with `parity_err` or `frame_err` set (one increment per frame even if both), saturating at 255; cleared only by reset.
- Undefined: no counter logic; `err_count` tied to 0.

## Test plan
- `wordsize`=8, strobes every 4 clocks: send 0, bits of 0xA5 LSB first, parity 0, stop 1 → `data`=0xA5, `valid` one cycle, `parity_err`=0, `frame_err`=0, `busy` low after stop.
- Same frame with parity bit 1 → `data`=0xA5, `parity_err`=1; with macro, `err_count`=1.
- 0x3C, parity 0, stop 0 → `data`=0x3C, `frame_err`=1, `parity_err`=0; next frame 0x01, parity 1, stop 1 received correctly with both flags 0.
- `bit_en` tied high, frames 0x00 (parity 0) then 0xFF (parity 0) back-to-back, no idle bit → two `valid` pulses 11 clocks apart, data 0x00 then 0xFF.
- `rst_n` pulsed low after 4 data bits → all outputs 0 immediately, no `valid`; following clean frame 0x5A decoded correctly.
- Macro defined: 300 frames with bad parity → `err_count` saturates at 255; macro undefined → `err_count` stays 0.
